// File: rtl/cv32e40x_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : cv32e40x_pkg                                                    |
// | Brief  : Shared constants, types and helpers for the CLINT-lite block.   |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
package cv32e40x_pkg;

  localparam int unsigned CSR_MSIX_BIT = 3;
  localparam int unsigned CSR_MTIX_BIT = 7;

  localparam logic [4:0] CLINT_MSIP_OFFSET        = 5'h00;
  localparam logic [4:0] CLINT_MTIMECMP_LO_OFFSET = 5'h08;
  localparam logic [4:0] CLINT_MTIMECMP_HI_OFFSET = 5'h0C;
  localparam logic [4:0] CLINT_MTIME_LO_OFFSET    = 5'h10;
  localparam logic [4:0] CLINT_MTIME_HI_OFFSET    = 5'h14;
  localparam logic [4:0] CLINT_PRESCALE_OFFSET    = 5'h18;

  typedef enum logic [2:0] {
    CLINT_REG_MSIP        = 3'd0,
    CLINT_REG_MTIMECMP_LO = 3'd1,
    CLINT_REG_MTIMECMP_HI = 3'd2,
    CLINT_REG_MTIME_LO    = 3'd3,
    CLINT_REG_MTIME_HI    = 3'd4,
    CLINT_REG_PRESCALE    = 3'd5,
    CLINT_REG_NONE        = 3'd7
  } clint_reg_e;

  typedef struct packed {
    logic mtimecmp_lo;
    logic mtimecmp_hi;
    logic mtime_lo;
    logic mtime_hi;
    logic prescale;
  } clint_timer_wr_t;

  // Misaligned addresses never match an offset, so they decode to NONE as well.
  function automatic clint_reg_e clint_decode(input logic [4:0] addr);
    clint_reg_e sel;
    case (addr)
      CLINT_MSIP_OFFSET:        sel = CLINT_REG_MSIP;
      CLINT_MTIMECMP_LO_OFFSET: sel = CLINT_REG_MTIMECMP_LO;
      CLINT_MTIMECMP_HI_OFFSET: sel = CLINT_REG_MTIMECMP_HI;
      CLINT_MTIME_LO_OFFSET:    sel = CLINT_REG_MTIME_LO;
      CLINT_MTIME_HI_OFFSET:    sel = CLINT_REG_MTIME_HI;
      CLINT_PRESCALE_OFFSET:    sel = CLINT_REG_PRESCALE;
      default:                  sel = CLINT_REG_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] clint_byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cv32e40x_clint_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : cv32e40x_clint_timer                                            |
// | Brief  : Prescaler, 64-bit mtime/mtimecmp with byte merge, timer irq.    |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module cv32e40x_clint_timer
  import cv32e40x_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = 16,
  parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  clint_timer_wr_t           wr_i,
  input  logic [3:0]                be_i,
  input  logic [31:0]               wdata_i,
  output logic [63:0]               mtime_o,
  output logic [63:0]               mtimecmp_o,
  output logic [PRESCALE_WIDTH-1:0] prescale_o,
  output logic                      irq_timer_o
);

  logic [PRESCALE_WIDTH-1:0] r_pcnt;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [PRESCALE_WIDTH-1:0] w_pcnt_d;
  logic [PRESCALE_WIDTH-1:0] w_prescale_d;
  logic [PRESCALE_WIDTH-1:0] w_prescale_mask;
  logic [63:0]               r_mtime;
  logic [63:0]               r_mtimecmp;
  logic [63:0]               w_mtime_inc;
  logic [63:0]               w_mtime_d;
  logic [63:0]               w_mtimecmp_d;
  logic [63:0]               w_mtime_mask;
  logic [63:0]               w_mtimecmp_mask;
  logic [63:0]               w_wdata64;
  logic [31:0]               w_mask;
  logic                      w_tick;
  logic                      r_irq_timer;

  assign w_mask    = clint_byte_mask(be_i);
  assign w_wdata64 = {wdata_i, wdata_i};

  assign w_mtime_mask    = {wr_i.mtime_hi    ? w_mask : 32'h0, wr_i.mtime_lo    ? w_mask : 32'h0};
  assign w_mtimecmp_mask = {wr_i.mtimecmp_hi ? w_mask : 32'h0, wr_i.mtimecmp_lo ? w_mask : 32'h0};
  assign w_prescale_mask = wr_i.prescale ? w_mask[PRESCALE_WIDTH-1:0] : '0;

  assign w_tick = (r_pcnt == r_prescale);

  // Unwritten bytes take the incremented value so a carry is never lost.
  assign w_mtime_inc  = r_mtime + {63'd0, w_tick};
  assign w_mtime_d    = (w_mtime_inc & ~w_mtime_mask) | (w_wdata64 & w_mtime_mask);
  assign w_mtimecmp_d = (r_mtimecmp & ~w_mtimecmp_mask) | (w_wdata64 & w_mtimecmp_mask);
  assign w_prescale_d = (r_prescale & ~w_prescale_mask)
                      | (wdata_i[PRESCALE_WIDTH-1:0] & w_prescale_mask);

  always_comb begin
    w_pcnt_d = r_pcnt + PRESCALE_WIDTH'(1);
    if (wr_i.prescale || w_tick) begin
      w_pcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt      <= '0;
      r_prescale  <= '0;
      r_mtime     <= '0;
      r_mtimecmp  <= MTIMECMP_RESET;
      r_irq_timer <= 1'b0;
    end else begin
      r_pcnt      <= w_pcnt_d;
      r_prescale  <= w_prescale_d;
      r_mtime     <= w_mtime_d;
      r_mtimecmp  <= w_mtimecmp_d;
      r_irq_timer <= (r_mtime >= r_mtimecmp);
    end
  end

  assign mtime_o     = r_mtime;
  assign mtimecmp_o  = r_mtimecmp;
  assign prescale_o  = r_prescale;
  assign irq_timer_o = r_irq_timer;

endmodule
`default_nettype wire

// File: rtl/cv32e40x_clint_lite.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : cv32e40x_clint_lite                                             |
// | Brief  : Bus slave with msip and machine timer driving core irq lines.   |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module cv32e40x_clint_lite
  import cv32e40x_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = 16,
  parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [63:0] mtime_o,
  output logic [31:0] irq_o
);

  clint_reg_e                w_sel;
  clint_timer_wr_t           w_timer_wr;
  logic                      w_addr_err;
  logic                      w_wr_ok;
  logic                      w_rd_ok;
  logic                      w_msip_d;
  logic                      r_msip;
  logic [31:0]               w_rdata;
  logic [31:0]               w_prescale32;
  logic                      r_rvalid;
  logic                      r_err;
  logic [31:0]               r_rdata;
  logic [63:0]               w_mtime;
  logic [63:0]               w_mtimecmp;
  logic [PRESCALE_WIDTH-1:0] w_prescale;
  logic                      w_irq_timer;

  assign gnt_o      = req_i;
  assign w_sel      = clint_decode(addr_i);
  assign w_addr_err = (w_sel == CLINT_REG_NONE);
  assign w_wr_ok    = req_i & we_i & ~w_addr_err;
  assign w_rd_ok    = req_i & ~we_i & ~w_addr_err;

  always_comb begin
    w_timer_wr = '0;
    if (w_wr_ok) begin
      case (w_sel)
        CLINT_REG_MTIMECMP_LO: w_timer_wr.mtimecmp_lo = 1'b1;
        CLINT_REG_MTIMECMP_HI: w_timer_wr.mtimecmp_hi = 1'b1;
        CLINT_REG_MTIME_LO:    w_timer_wr.mtime_lo    = 1'b1;
        CLINT_REG_MTIME_HI:    w_timer_wr.mtime_hi    = 1'b1;
        CLINT_REG_PRESCALE:    w_timer_wr.prescale    = 1'b1;
        default:               w_timer_wr             = '0;
      endcase
    end
  end

  cv32e40x_clint_timer #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH),
    .MTIMECMP_RESET (MTIMECMP_RESET)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_i        (w_timer_wr),
    .be_i        (be_i),
    .wdata_i     (wdata_i),
    .mtime_o     (w_mtime),
    .mtimecmp_o  (w_mtimecmp),
    .prescale_o  (w_prescale),
    .irq_timer_o (w_irq_timer)
  );

  always_comb begin
    w_msip_d = r_msip;
    if (w_wr_ok && (w_sel == CLINT_REG_MSIP) && be_i[0]) begin
      w_msip_d = wdata_i[0];
    end
  end

  assign w_prescale32 = 32'(w_prescale);

  // Reads see the register values in front of the accepting edge.
  always_comb begin
    w_rdata = 32'h0;
    if (w_rd_ok) begin
      case (w_sel)
        CLINT_REG_MSIP:        w_rdata = {31'h0, r_msip};
        CLINT_REG_MTIMECMP_LO: w_rdata = w_mtimecmp[31:0];
        CLINT_REG_MTIMECMP_HI: w_rdata = w_mtimecmp[63:32];
        CLINT_REG_MTIME_LO:    w_rdata = w_mtime[31:0];
        CLINT_REG_MTIME_HI:    w_rdata = w_mtime[63:32];
        CLINT_REG_PRESCALE:    w_rdata = w_prescale32;
        default:               w_rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_msip   <= 1'b0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= 32'h0;
    end else begin
      r_msip   <= w_msip_d;
      r_rvalid <= req_i;
      r_err    <= req_i & w_addr_err;
      r_rdata  <= w_rdata;
    end
  end

  assign rvalid_o = r_rvalid;
  assign err_o    = r_err;
  assign rdata_o  = r_rdata;
  assign mtime_o  = w_mtime;

  always_comb begin
    irq_o               = 32'h0;
    irq_o[CSR_MTIX_BIT] = w_irq_timer;
    irq_o[CSR_MSIX_BIT] = r_msip;
  end

endmodule
`default_nettype wire

// File: tb/tb_cv32e40x_clint_lite.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_cv32e40x_clint_lite                                          |
// | Brief  : Vector table, directed timer sequences and random bus traffic.  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_cv32e40x_clint_lite;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i;
  logic        gnt_o;
  logic        we_i;
  logic [3:0]  be_i;
  logic [4:0]  addr_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [63:0] mtime_o;
  logic [31:0] irq_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cv32e40x_clint_lite #(
    .PRESCALE_WIDTH (16),
    .MTIMECMP_RESET (64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .we_i     (we_i),
    .be_i     (be_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .mtime_o  (mtime_o),
    .irq_o    (irq_o)
  );

  // Reference state: timer ticks derived from cycles elapsed since the last prescale write.
  logic [63:0]     m_mtime;
  logic [63:0]     m_cmp;
  logic [15:0]     m_presc;
  logic            m_msip;
  logic            m_irq_t;
  longint unsigned m_phase;
  logic            exp_rvalid;
  logic            exp_err;
  logic [31:0]     exp_rdata;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t       vecs [25];
  logic [4:0] addrs [10] = '{5'h00, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h04, 5'h1C, 5'h02, 5'h13};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mtime = 64'h0;
    m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    m_presc = 16'h0;
    m_msip  = 1'b0;
    m_irq_t = 1'b0;
    m_phase = 0;
  endtask

  function automatic logic m_valid(input logic [4:0] a);
    return (a == 5'h00) || (a == 5'h08) || (a == 5'h0C) || (a == 5'h10) || (a == 5'h14) || (a == 5'h18);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'h00:   return {31'h0, m_msip};
      5'h08:   return m_cmp[31:0];
      5'h0C:   return m_cmp[63:32];
      5'h10:   return m_mtime[31:0];
      5'h14:   return m_mtime[63:32];
      5'h18:   return {16'h0, m_presc};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] mask;
    mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  task automatic model_step(input logic r, input logic w, input logic [3:0] b,
                            input logic [4:0] a, input logic [31:0] d);
    logic            valid;
    logic            wr;
    logic            tick;
    logic [63:0]     inc;
    longint unsigned p;
    valid      = m_valid(a);
    wr         = r && w && valid;
    exp_rvalid = r;
    exp_err    = r && !valid;
    exp_rdata  = (r && !w && valid) ? m_read(a) : 32'h0;
    p          = longint'(m_presc);
    tick       = ((m_phase % (p + 1)) == p);
    inc        = m_mtime + (tick ? 64'd1 : 64'd0);
    m_irq_t    = (m_mtime >= m_cmp);
    m_mtime    = inc;
    if (wr && a == 5'h10) m_mtime[31:0]  = merge(inc[31:0], d, b);
    if (wr && a == 5'h14) m_mtime[63:32] = merge(inc[63:32], d, b);
    if (wr && a == 5'h08) m_cmp[31:0]    = merge(m_cmp[31:0], d, b);
    if (wr && a == 5'h0C) m_cmp[63:32]   = merge(m_cmp[63:32], d, b);
    if (wr && a == 5'h00 && b[0]) m_msip = d[0];
    if (wr && a == 5'h18) begin
      m_presc = 16'(merge({16'h0, m_presc}, d, b));
      m_phase = 0;
    end else begin
      m_phase++;
    end
  endtask

  task automatic do_cycle(input logic r, input logic w, input logic [3:0] b,
                          input logic [4:0] a, input logic [31:0] d);
    req_i = r; we_i = w; be_i = b; addr_i = a; wdata_i = d;
    #1;
    chk("gnt", gnt_o, r);
    model_step(r, w, b, a, d);
    @(posedge clk);
    #1;
    chk("rvalid", rvalid_o, exp_rvalid);
    if (exp_rvalid) begin
      chk("err", err_o, exp_err);
      chk("rdata", rdata_o, exp_rdata);
    end
    chk("mtime", mtime_o, m_mtime);
    chk("irq", irq_o, {24'h0, m_irq_t, 3'b0, m_msip, 3'b0});
  endtask

  task automatic idle();
    do_cycle(1'b0, 1'b0, 4'h0, 5'h00, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] target;
    logic [63:0] m0;
    logic        seen;

    vecs[0]  = '{1'b0, 4'h0, 5'h00, 32'h0,         1'b0, 32'h0};
    vecs[1]  = '{1'b0, 4'h0, 5'h08, 32'h0,         1'b0, 32'hFFFF_FFFF};
    vecs[2]  = '{1'b0, 4'h0, 5'h0C, 32'h0,         1'b0, 32'hFFFF_FFFF};
    vecs[3]  = '{1'b0, 4'h0, 5'h18, 32'h0,         1'b0, 32'h0};
    vecs[4]  = '{1'b0, 4'h0, 5'h04, 32'h0,         1'b1, 32'h0};
    vecs[5]  = '{1'b0, 4'h0, 5'h02, 32'h0,         1'b1, 32'h0};
    vecs[6]  = '{1'b1, 4'hF, 5'h1C, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 4'h0, 5'h18, 32'h0,         1'b0, 32'h0};
    vecs[8]  = '{1'b1, 4'h2, 5'h00, 32'h1,         1'b0, 32'h0};
    vecs[9]  = '{1'b0, 4'h0, 5'h00, 32'h0,         1'b0, 32'h0};
    vecs[10] = '{1'b1, 4'h1, 5'h00, 32'h1,         1'b0, 32'h0};
    vecs[11] = '{1'b0, 4'h0, 5'h00, 32'h0,         1'b0, 32'h1};
    vecs[12] = '{1'b1, 4'h0, 5'h00, 32'h0,         1'b0, 32'h0};
    vecs[13] = '{1'b0, 4'h0, 5'h00, 32'h0,         1'b0, 32'h1};
    vecs[14] = '{1'b1, 4'hF, 5'h18, 32'hFFFF_0005, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 4'h0, 5'h18, 32'h0,         1'b0, 32'h5};
    vecs[16] = '{1'b1, 4'h3, 5'h18, 32'h0,         1'b0, 32'h0};
    vecs[17] = '{1'b0, 4'h0, 5'h18, 32'h0,         1'b0, 32'h0};
    vecs[18] = '{1'b1, 4'h1, 5'h00, 32'h0,         1'b0, 32'h0};
    vecs[19] = '{1'b1, 4'h1, 5'h08, 32'h12,        1'b0, 32'h0};
    vecs[20] = '{1'b0, 4'h0, 5'h08, 32'h0,         1'b0, 32'hFFFF_FF12};
    vecs[21] = '{1'b1, 4'hF, 5'h08, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[22] = '{1'b0, 4'h0, 5'h13, 32'h0,         1'b1, 32'h0};
    vecs[23] = '{1'b1, 4'hF, 5'h0A, 32'h0,         1'b1, 32'h0};
    vecs[24] = '{1'b0, 4'h0, 5'h08, 32'h0,         1'b0, 32'hFFFF_FFFF};

    rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = 5'h0; wdata_i = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rvalid", rvalid_o, 1'b0);
    chk("reset_err", err_o, 1'b0);
    chk("reset_rdata", rdata_o, 32'h0);
    chk("reset_irq", irq_o, 32'h0);
    chk("reset_mtime", mtime_o, 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      do_cycle(1'b1, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d_rvalid", i), rvalid_o, 1'b1);
      chk($sformatf("vec%0d_err", i), err_o, vecs[i].exp_err);
      chk($sformatf("vec%0d_rdata", i), rdata_o, vecs[i].exp_rdata);
    end

    // Timer interrupt rises one cycle after mtime reaches mtimecmp.
    do_cycle(1'b1, 1'b1, 4'hF, 5'h0C, 32'h0);
    target = m_mtime[31:0] + 32'd20;
    do_cycle(1'b1, 1'b1, 4'hF, 5'h08, target);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      idle();
      if (mtime_o == {32'h0, target}) begin
        seen = 1'b1;
        chk("tmr_irq_at_equal", irq_o[7], 1'b0);
        idle();
        chk("tmr_irq_after_equal", irq_o[7], 1'b1);
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL tmr_reach actual=not_reached required=%h", target);
    end
    do_cycle(1'b1, 1'b1, 4'hF, 5'h0C, 32'h1);
    chk("tmr_irq_hold", irq_o[7], 1'b1);
    idle();
    chk("tmr_irq_clear", irq_o[7], 1'b0);

    // Prescale of 3: first increment four edges after the write edge.
    do_cycle(1'b1, 1'b1, 4'hF, 5'h18, 32'h3);
    m0 = m_mtime;
    for (int i = 1; i <= 8; i++) begin
      idle();
      chk($sformatf("presc_mtime%0d", i), mtime_o, m0 + 64'(i / 4));
    end
    do_cycle(1'b1, 1'b1, 4'hF, 5'h18, 32'h0);

    // Carry across the 32-bit halves, write-over-tick and full 64-bit wrap.
    do_cycle(1'b1, 1'b1, 4'hF, 5'h14, 32'h0);
    do_cycle(1'b1, 1'b1, 4'hF, 5'h10, 32'hFFFF_FFFF);
    chk("wrap_pre", mtime_o, 64'h0000_0000_FFFF_FFFF);
    idle();
    chk("wrap_carry", mtime_o, 64'h0000_0001_0000_0000);
    do_cycle(1'b1, 1'b1, 4'hF, 5'h10, 32'h5);
    chk("write_over_tick", mtime_o, 64'h0000_0001_0000_0005);
    do_cycle(1'b1, 1'b1, 4'hF, 5'h14, 32'hFFFF_FFFF);
    do_cycle(1'b1, 1'b1, 4'hF, 5'h10, 32'hFFFF_FFFE);
    idle();
    chk("wrap_allones", mtime_o, 64'hFFFF_FFFF_FFFF_FFFF);
    idle();
    chk("wrap_zero", mtime_o, 64'h0);

    for (int i = 0; i < 400; i++) begin
      logic [4:0]  a;
      logic [31:0] d;
      a = addrs[$urandom_range(0, 9)];
      d = $urandom;
      if (a == 5'h18) d = 32'($urandom_range(0, 3));
      do_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom), a, d);
    end

    // Reset while a request is in flight.
    do_cycle(1'b1, 1'b1, 4'h1, 5'h00, 32'h1);
    req_i = 1'b1; we_i = 1'b0; be_i = 4'h0; addr_i = 5'h00;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rvalid", rvalid_o, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_mid_rvalid_after", rvalid_o, 1'b0);
    chk("rst_mid_irq", irq_o, 32'h0);
    chk("rst_mid_mtime", mtime_o, 64'h0);
    req_i = 1'b0;
    rst_n = 1'b1;
    model_reset();
    do_cycle(1'b1, 1'b0, 4'h0, 5'h00, 32'h0);
    do_cycle(1'b1, 1'b0, 4'h0, 5'h08, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cv32e40x_clint_lite.md
Name: cv32e40x_clint_lite

Overview:
- Memory-mapped interrupt source: the generator side of the core's level-triggered interrupt inputs.
- Holds a 64-bit machine timer with a prescaler, a 64-bit timer compare register and a software-interrupt bit.
- Drives MTI (irq line 7) and MSI (irq line 3) as registered levels, packed into a 32-bit vector that connects directly to the core's irq inputs.
- Sits on a simple single-cycle-grant data bus slave port next to the core.

Parameters:
- PRESCALE_WIDTH, 16, width of the prescaler reload register and counter.
- MTIMECMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp; the timer interrupt is never pending out of reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_i  in  1  bus request
- gnt_o  out  1  bus grant; combinational, equals req_i
- we_i  in  1  1 = write, 0 = read
- be_i  in  4  byte enables (writes only)
- addr_i  in  5  byte address within the block
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid, exactly 1 cycle after an accepted request
- rdata_o  out  32  read data; 0 for writes and for errors
- err_o  out  1  error response, qualified by rvalid_o
- mtime_o  out  64  current timer value (mtime_q)
- irq_o  out  32  interrupt vector: bit 3 = irq_soft, bit 7 = irq_timer, all other bits 0

Behaviour:
- Register map, word aligned:
  - 0x00 MSIP: bit0 = msip, bits 31:1 read as 0
  - 0x08 MTIMECMP_LO
  - 0x0C MTIMECMP_HI
  - 0x10 MTIME_LO
  - 0x14 MTIME_HI
  - 0x18 PRESCALE: bits PRESCALE_WIDTH-1:0 writable, upper bits read as 0
- Errors: addr_i[1:0] != 0, or any unmapped offset -> err_o=1 and rdata_o=0. An erroring write changes no state.
- Handshake:
  - A request is accepted in every cycle req_i=1; no back-pressure.
  - Response is registered: rvalid_o=1 in the cycle after acceptance.
  - Back-to-back requests give back-to-back responses.
- Writes:
  - Honour be_i per byte; be_i=0 is a legal no-op write with err_o=0.
  - Write takes effect at the clock edge that accepts the request.
- Reads: return the register value as it was at the acceptance edge, i.e. the pre-write value for any concurrent state change.
- Prescaler:
  - Counter pcnt counts up each cycle.
  - When pcnt == PRESCALE, assert tick and clear pcnt.
  - PRESCALE=0 gives a tick every cycle; PRESCALE=N gives a tick every N+1 cycles.
  - Any accepted write to PRESCALE clears pcnt in the same edge.
- mtime:
  - On tick, mtime_q <= mtime_q+1 as a full 64-bit increment; carry propagates lo->hi; wraps from all-ones to 0.
  - A bus write to MTIME_LO/HI in the same cycle as tick: the written bytes take the written value; unwritten bytes of the 64-bit word take the incremented value.
- Timer interrupt:
  - irq_timer_q <= (mtime_q >= mtimecmp_q), unsigned 64-bit compare, evaluated every cycle.
  - When mtime_q first equals mtimecmp_q in cycle N, irq_timer is high from cycle N+1.
  - A mtimecmp write accepted at edge E updates the register at E; irq reflects the new value after edge E+1.
  - Level only, no latching: it stays high until mtimecmp is raised above mtime or mtime wraps.
  - Split 32-bit updates are not atomic. Software writes MTIMECMP_HI to all-ones first, then LO, then HI.
- Software interrupt: irq_soft = msip_q; a write with be_i[0]=1 sets msip to wdata_i[0]; visible on irq_o the cycle after the accepting edge.
- Reset values:
  - mtime=0, pcnt=0, PRESCALE=0, msip=0
  - mtimecmp=MTIMECMP_RESET
  - irq_o=0, rvalid_o=0, err_o=0, rdata_o=0
- Reset mid-transaction: a pending response is dropped (rvalid_o=0); no partial write persists.

Decomposition:
- Shared package cv32e40x_pkg gets:
  - register offset constants CLINT_MSIP_OFFSET, CLINT_MTIMECMP_LO_OFFSET, CLINT_MTIMECMP_HI_OFFSET, CLINT_MTIME_LO_OFFSET, CLINT_MTIME_HI_OFFSET, CLINT_PRESCALE_OFFSET;
  - reuse of the existing CSR_MTIX_BIT/CSR_MSIX_BIT for irq_o bit placement.
- One sub-module, cv32e40x_clint_timer: prescaler, 64-bit mtime with byte-enable write merge, mtimecmp, compare and irq_timer register.
- Top level holds bus decode, response register and msip.

Test Plan:
- Reset, then read every register -> MSIP=0, MTIMECMP_LO/HI=0xFFFFFFFF, MTIME advances from 0, PRESCALE=0, irq_o=0.
- Write MSIP=1 with be=4'b0001 -> irq_o=32'h8 one cycle after acceptance; write MSIP=0 -> irq_o=0. Write MSIP=1 with be=4'b0010 -> no change.
- PRESCALE=0; write MTIMECMP_HI=0, then MTIMECMP_LO=mtime+20 -> irq_o[7] rises exactly 1 cycle after mtime_o reaches the compare value; raising MTIMECMP_HI to 1 clears it 2 cycles after acceptance.
- Write PRESCALE=3 -> mtime_o increments every 4 cycles, first increment 4 cycles after the write edge.
- Set MTIME_LO=0xFFFFFFFF, MTIME_HI=0 with PRESCALE=0 -> next tick gives MTIME_HI=1, MTIME_LO=0. Write MTIME_LO=5 in a tick cycle -> MTIME_LO=5, no increment applied.
- Read 0x04, read 0x02, write 0x1C -> each returns rvalid_o=1, err_o=1, rdata_o=0, no state change. Back-to-back mixed reads/writes -> one response per cycle, in order.
